mem_host_port: RTL and testbench
================================

MEM_HOST_PORT -- requirements
Module: mem_host_port

Interface
REQ-001 Parameter: N_CH, 3, number of memory channels served (inst/param/act in base configuration).
REQ-002 Parameter: DATA_W, 128, widest channel data width; narrower memories use LSBs.
REQ-003 Parameter: ADDR_W, 13, address width, common to all channels.
REQ-004 Parameter: LEN_W, 8, burst length field width; CH_W = max(1, ceil(log2 N_CH)) derived.
REQ-005 Ports: clk  in  1  sole clock, all state rising-edge.
REQ-006 Ports: reset  in  1  asynchronous, active-high reset.
REQ-007 Ports: cmd_valid/cmd_ready  in/out  1/1  host command handshake.
REQ-008 Ports: cmd_ch, cmd_write, cmd_addr, cmd_len, cmd_stride  in  CH_W/1/ADDR_W/LEN_W/ADDR_W  target channel, direction, start address, beats-1, address increment.
REQ-009 Ports: cmd_abort  in  1  terminate active burst.
REQ-010 Ports: wdata/wvalid/wready  in/in/out  DATA_W/1/1  host write beat stream.
REQ-011 Ports: rdata/rvalid  out  DATA_W/1  host read beat stream, no backpressure.
REQ-012 Ports: busy/err  out  1/1  burst in progress; one-cycle illegal-channel pulse.
REQ-013 Ports: core_req, core_we  in  N_CH each  per-channel core access request and write enable.
REQ-014 Ports: core_addr/core_wdata  in  N_CH*ADDR_W / N_CH*DATA_W  flattened, channel c at slice c.
REQ-015 Ports: mem_we/mem_addr/mem_wdata  out  N_CH / N_CH*ADDR_W / N_CH*DATA_W  to synchronous single-port RAMs.
REQ-016 Ports: mem_rdata  in  N_CH*DATA_W  RAM outputs, valid one cycle after address.

Function
REQ-017 Core priority: channel c is core-owned whenever core_req[c]=1 or c is not the active burst target; then mem_we[c]=core_req[c]&core_we[c], mem_addr/mem_wdata = core slices.
REQ-018 Host drives only the target channel, only in RUN, only in cycles where core_req[ch]=0.
REQ-019 FSM states IDLE, RUN, DRAIN; cmd_ready=1 only in IDLE; busy=1 in RUN or DRAIN.
REQ-020 Accept on cmd_valid&cmd_ready: latch ch, write, addr, len, stride; beat counter = cmd_len; go RUN next cycle.
REQ-021 cmd_ch >= N_CH: err=1 for exactly next cycle, command dropped, stay IDLE.
REQ-022 Write burst: wready = RUN & write & !core_req[ch]; beat fires on wvalid&wready: mem_we[ch]=1, mem_addr=current addr, mem_wdata=wdata.
REQ-023 Read burst: beat issues in every RUN cycle with !core_req[ch]; mem_we[ch]=0.
REQ-024 Per fired/issued beat: addr += stride modulo 2^ADDR_W (wraps, stride 0 legal); counter decrements.
REQ-025 Stalled beat (core_req[ch]=1 or wvalid=0) holds address and counter unchanged.
REQ-026 Burst = cmd_len+1 beats; write: last beat -> IDLE next cycle; read: last issue -> DRAIN.
REQ-027 Read latency: beat issued in cycle T yields rvalid=1 in cycle T+2 with rdata = RAM word at issued address; rdata registered.
REQ-028 Only host-issued beats produce rvalid; core reads on the same channel never do.
REQ-029 DRAIN lasts exactly 2 cycles (final rvalid in second), then IDLE.
REQ-030 cmd_abort in RUN or DRAIN: IDLE next cycle, no further mem_we, all in-flight read beats suppressed (no rvalid); ignored in IDLE.
REQ-031 cmd_valid while busy is not accepted and has no effect.

Reset
REQ-032 reset asserted: state IDLE, rvalid=0, rdata=0, err=0, busy=0, wready=0, counters/address 0, read pipeline cleared, immediately (asynchronous).
REQ-033 During reset, memory outputs follow core pass-through per REQ-017; cmd_ready=1 after release.
REQ-034 reset mid-burst: burst discarded, no pending rvalid after release.

Verification
REQ-035 Write ch1, addr 0x010, len 3, stride 1, wvalid constant -> mem_we[1] on 4 consecutive cycles at 0x010..0x013, IDLE after 4th.
REQ-036 Read ch2, addr 0x0FF0, len 1, stride 0x20 -> issues at 0x0FF0, 0x1010; rvalid at T+2, T+3 with stored words; busy low 2 cycles after last issue.
REQ-037 Read ch0, len 4, core_req[0]=1 for 3 cycles mid-burst -> core gets channel, address held, still exactly 5 rvalids, in order.
REQ-038 cmd_ch=3 with N_CH=3 -> err one-cycle pulse, no mem_we, cmd_ready stays 1.
REQ-039 Read addr 0x1FFF, stride 2, len 1 -> second address 0x0001 (wrap); cmd_abort in DRAIN cycle 1 -> no further rvalid, IDLE next.
REQ-040 reset asserted during write beat 2 of 4 -> busy, wready, rvalid 0 at once; post-release new command accepted normally.

Source files
------------

// File: rtl/mem_host_port.sv
// mem_host_port: lets a host run strided read/write bursts into one of N_CH
// synchronous single-port RAMs while the core keeps priority on every channel.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             host command handshake (ready only when idle)
//   cmd_ch/write/addr/len/stride    target channel, direction, start address,
//                                   beats-1, address increment
//   cmd_abort                       terminate the active burst
//   wdata/wvalid/wready             host write beat stream
//   rdata/rvalid                    host read beat stream (no backpressure)
//   busy, err                       burst in progress; one-cycle bad-channel pulse
//   core_req/core_we/core_addr/
//   core_wdata                      per-channel core access (flattened slices)
//   mem_we/mem_addr/mem_wdata       per-channel RAM controls (flattened slices)
//   mem_rdata                       per-channel RAM read data, one cycle latency
module mem_host_port #(
    parameter int unsigned N_CH   = 3,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned LEN_W  = 8,
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CH_W-1:0]          cmd_ch,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [LEN_W-1:0]         cmd_len,
    input  logic [ADDR_W-1:0]        cmd_stride,
    input  logic                     cmd_abort,

    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wvalid,
    output logic                     wready,

    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,

    output logic                     busy,
    output logic                     err,

    input  logic [N_CH-1:0]          core_req,
    input  logic [N_CH-1:0]          core_we,
    input  logic [N_CH*ADDR_W-1:0]   core_addr,
    input  logic [N_CH*DATA_W-1:0]   core_wdata,

    output logic [N_CH-1:0]          mem_we,
    output logic [N_CH*ADDR_W-1:0]   mem_addr,
    output logic [N_CH*DATA_W-1:0]   mem_wdata,
    input  logic [N_CH*DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic                wr;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   stride;
    logic [LEN_W-1:0]    cnt;
    logic                drain_last;
    logic                iss_d1;

    logic                core_tgt;
    logic [DATA_W-1:0]   rd_sel;
    logic                run;
    logic                host_beat;
    logic                abort_act;
    logic                ch_bad;

    // Status decoded straight from the state register
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign run       = (state == RUN);

    // Core request and RAM read data of the latched target channel
    always_comb begin
        core_tgt = 1'b0;
        rd_sel   = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (ch == CH_W'(c)) begin
                core_tgt = core_req[c];
                rd_sel   = mem_rdata[c*DATA_W +: DATA_W];
            end
        end
    end

    // A beat moves only when the core leaves the target channel alone;
    // write beats additionally need host data.
    assign host_beat = run && !core_tgt && (!wr || wvalid);
    assign wready    = run && wr && !core_tgt;
    assign abort_act = cmd_abort && (state != IDLE);
    assign ch_bad    = ({1'b0, cmd_ch} >= (CH_W+1)'(N_CH));

    // RAM steering: core pass-through everywhere, host overrides its target on a beat
    always_comb begin
        mem_we    = core_req & core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (host_beat && (ch == CH_W'(c))) begin
                mem_we[c]                      = wr;
                mem_addr[c*ADDR_W +: ADDR_W]   = addr;
                if (wr) begin
                    mem_wdata[c*DATA_W +: DATA_W] = wdata;
                end
            end
        end
    end

    // Burst FSM, address/count tracking and the two-stage read return pipe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ch         <= '0;
            wr         <= 1'b0;
            addr       <= '0;
            stride     <= '0;
            cnt        <= '0;
            drain_last <= 1'b0;
            iss_d1     <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;

            // Stage 1 marks a host read issued last cycle; stage 2 captures RAM data.
            // An abort kills both stages, including a beat issued in the abort cycle.
            iss_d1 <= host_beat && !wr && !abort_act;
            rvalid <= iss_d1 && !abort_act;
            if (iss_d1 && !abort_act) begin
                rdata <= rd_sel;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (ch_bad) begin
                            err <= 1'b1;
                        end else begin
                            ch     <= cmd_ch;
                            wr     <= cmd_write;
                            addr   <= cmd_addr;
                            stride <= cmd_stride;
                            cnt    <= cmd_len;
                            state  <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (abort_act) begin
                        state <= IDLE;
                    end else if (host_beat) begin
                        addr <= addr + stride;
                        if (cnt == '0) begin
                            drain_last <= 1'b0;
                            state      <= wr ? IDLE : DRAIN;
                        end else begin
                            cnt <= cnt - LEN_W'(1);
                        end
                    end
                end

                // Two cycles so the last issued read can return
                DRAIN: begin
                    if (abort_act || drain_last) begin
                        state <= IDLE;
                    end else begin
                        drain_last <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_host_port.sv
// tb_mem_host_port: directed bench for mem_host_port with a behavioural
// model of three synchronous single-port RAMs (one-cycle read latency).
// Unwritten RAM words read back a known address-derived pattern.
module tb_mem_host_port;

    localparam int unsigned N_CH   = 3;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned CH_W   = 2;

    logic                   clk;
    logic                   reset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [CH_W-1:0]        cmd_ch;
    logic                   cmd_write;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [LEN_W-1:0]       cmd_len;
    logic [ADDR_W-1:0]      cmd_stride;
    logic                   cmd_abort;
    logic [DATA_W-1:0]      wdata;
    logic                   wvalid;
    logic                   wready;
    logic [DATA_W-1:0]      rdata;
    logic                   rvalid;
    logic                   busy;
    logic                   err;
    logic [N_CH-1:0]        core_req;
    logic [N_CH-1:0]        core_we;
    logic [N_CH*ADDR_W-1:0] core_addr;
    logic [N_CH*DATA_W-1:0] core_wdata;
    logic [N_CH-1:0]        mem_we;
    logic [N_CH*ADDR_W-1:0] mem_addr;
    logic [N_CH*DATA_W-1:0] mem_wdata;
    logic [N_CH*DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_host_port #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_stride (cmd_stride),
        .cmd_abort  (cmd_abort),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .busy       (busy),
        .err        (err),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default content of an unwritten RAM word
    function automatic logic [127:0] pat(input int c, input int a);
        return {32'hC0DE_0000 + 32'(c), 32'(a), 32'hFACE_0000 + 32'(a), 32'(a * 3 + c)};
    endfunction

    // Host/core write data for beat i
    function automatic logic [127:0] dpat(input int i);
        return {32'h1234_0000 + 32'(i), 32'hABCD_EF00, 32'(i), 32'h0BAD_F00D};
    endfunction

    // RAM model: read-first, registered output
    logic [127:0] wmem [int];
    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            int           k;
            logic [127:0] rd;
            k  = c * 8192 + int'(mem_addr[c*13 +: 13]);
            rd = wmem.exists(k) ? wmem[k] : pat(c, int'(mem_addr[c*13 +: 13]));
            mem_rdata[c*128 +: 128] <= rd;
            if (mem_we[c]) wmem[k] = mem_wdata[c*128 +: 128];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stall-pattern table for the core-interrupted read burst
    logic        c_cr [11];
    logic        c_cw [11];
    logic [2:0]  c_ewe[11];
    logic [12:0] c_ea [11];
    logic        c_ev [11];
    int          c_ed [11];
    logic        c_eb [11];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_stride = '0; cmd_abort = 1'b0; wdata = '0; wvalid = 1'b0;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0; mem_rdata = '0;

        // Reset: outputs cleared, core pass-through active
        #2;
        core_req = 3'b001; core_we = 3'b001; core_addr[12:0] = 13'h055; core_wdata[127:0] = dpat(9);
        #1;
        check("rst_mem_we",   128'(mem_we),         128'(3'b001));
        check("rst_mem_addr", 128'(mem_addr[12:0]), 128'(13'h055));
        check("rst_mem_wd",   mem_wdata[127:0],     dpat(9));
        check("rst_busy",     128'(busy),   128'(1'b0));
        check("rst_rvalid",   128'(rvalid), 128'(1'b0));
        check("rst_rdata",    rdata,        128'(0));
        check("rst_err",      128'(err),    128'(1'b0));
        check("rst_wready",   128'(wready), 128'(1'b0));
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        @(negedge clk); reset = 1'b0;
        #1 check("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));

        // Write ch1, 0x010, 4 beats, stride 1, wvalid held high
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_write = 1'b1; cmd_addr = 13'h010;
        cmd_len = 8'd3; cmd_stride = 13'd1; wvalid = 1'b1; wdata = dpat(0);
        #1 check("a_ready", 128'(cmd_ready), 128'(1'b1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cmd_valid = 1'b0; wdata = dpat(i);
            #1;
            check($sformatf("a_we%0d", i),   128'(mem_we),          128'(3'b010));
            check($sformatf("a_addr%0d", i), 128'(mem_addr[25:13]), 128'(13'h010 + 13'(i)));
            check($sformatf("a_wd%0d", i),   mem_wdata[255:128],    dpat(i));
            check($sformatf("a_busy%0d", i), 128'(busy),            128'(1'b1));
        end
        @(negedge clk); #1;
        check("a_idle_busy", 128'(busy),      128'(1'b0));
        check("a_idle_rdy",  128'(cmd_ready), 128'(1'b1));
        check("a_idle_we",   128'(mem_we),    128'(3'b000));
        wvalid = 1'b0;

        // Read ch2, 0x0FF0, 2 beats, stride 0x20
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_write = 1'b0; cmd_addr = 13'h0FF0;
        cmd_len = 8'd1; cmd_stride = 13'h020;
        @(negedge clk); cmd_valid = 1'b0; #1;
        check("b_addr0",  128'(mem_addr[38:26]), 128'(13'h0FF0));
        check("b_we0",    128'(mem_we),          128'(3'b000));
        check("b_rv0",    128'(rvalid),          128'(1'b0));
        @(negedge clk); #1;
        check("b_addr1",  128'(mem_addr[38:26]), 128'(13'h1010));
        check("b_rv1",    128'(rvalid),          128'(1'b0));
        @(negedge clk); #1;
        check("b_rv2",    128'(rvalid), 128'(1'b1));
        check("b_rd2",    rdata,        pat(2, 'h0FF0));
        check("b_busy2",  128'(busy),   128'(1'b1));
        @(negedge clk); #1;
        check("b_rv3",    128'(rvalid), 128'(1'b1));
        check("b_rd3",    rdata,        pat(2, 'h1010));
        check("b_busy3",  128'(busy),   128'(1'b1));
        @(negedge clk); #1;
        check("b_rv4",    128'(rvalid), 128'(1'b0));
        check("b_busy4",  128'(busy),   128'(1'b0));

        // Read ch0, 0x100, 5 beats; core takes ch0 for three cycles mid-burst
        c_cr  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        c_cw  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        c_ewe = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000,
                  3'b000, 3'b000, 3'b000};
        c_ea  = '{13'h100, 13'h101, 13'h0AA, 13'h0AA, 13'h0AA, 13'h102, 13'h103, 13'h104,
                  13'h0AA, 13'h0AA, 13'h0AA};
        c_ev  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        c_ed  = '{0, 0, 'h100, 'h101, 0, 0, 0, 'h102, 'h103, 'h104, 0};
        c_eb  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_write = 1'b0; cmd_addr = 13'h100;
        cmd_len = 8'd4; cmd_stride = 13'd1;
        core_addr[12:0] = 13'h0AA; core_wdata[127:0] = dpat(7);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk); cmd_valid = 1'b0;
            core_req[0] = c_cr[k]; core_we[0] = c_cw[k];
            #1;
            check($sformatf("c_we%0d", k),   128'(mem_we),         128'(c_ewe[k]));
            check($sformatf("c_addr%0d", k), 128'(mem_addr[12:0]), 128'(c_ea[k]));
            check($sformatf("c_rv%0d", k),   128'(rvalid),         128'(c_ev[k]));
            check($sformatf("c_busy%0d", k), 128'(busy),           128'(c_eb[k]));
            if (c_ev[k]) check($sformatf("c_rd%0d", k), rdata, pat(0, c_ed[k]));
            if (c_ewe[k][0]) check($sformatf("c_wd%0d", k), mem_wdata[127:0], dpat(7));
        end
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;

        // Illegal channel: err pulse, command dropped
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 2'd3; cmd_write = 1'b1; cmd_addr = 13'h300;
        cmd_len = 8'd0; wvalid = 1'b1; wdata = dpat(5);
        #1 check("d_ready0", 128'(cmd_ready), 128'(1'b1));
        @(negedge clk); cmd_valid = 1'b0; #1;
        check("d_err1",   128'(err),       128'(1'b1));
        check("d_we1",    128'(mem_we),    128'(3'b000));
        check("d_ready1", 128'(cmd_ready), 128'(1'b1));
        check("d_busy1",  128'(busy),      128'(1'b0));
        check("d_wrdy1",  128'(wready),    128'(1'b0));
        @(negedge clk); wvalid = 1'b0; #1;
        check("d_err2",   128'(err),       128'(1'b0));
        check("d_we2",    128'(mem_we),    128'(3'b000));

        // Read ch1 with address wrap, abort in first drain cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_write = 1'b0; cmd_addr = 13'h1FFF;
        cmd_len = 8'd1; cmd_stride = 13'd2;
        @(negedge clk); cmd_valid = 1'b0; #1;
        check("e_addr0", 128'(mem_addr[25:13]), 128'(13'h1FFF));
        @(negedge clk); #1;
        check("e_addr1", 128'(mem_addr[25:13]), 128'(13'h0001));
        @(negedge clk); cmd_abort = 1'b1; #1;
        check("e_rv2",   128'(rvalid), 128'(1'b1));
        check("e_rd2",   rdata,        pat(1, 'h1FFF));
        check("e_busy2", 128'(busy),   128'(1'b1));
        @(negedge clk); cmd_abort = 1'b0; #1;
        check("e_rv3",   128'(rvalid),    128'(1'b0));
        check("e_busy3", 128'(busy),      128'(1'b0));
        check("e_rdy3",  128'(cmd_ready), 128'(1'b1));
        @(negedge clk); #1;
        check("e_rv4",   128'(rvalid), 128'(1'b0));

        // Reset during beat 2 of a 4-beat write
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_write = 1'b1; cmd_addr = 13'h200;
        cmd_len = 8'd3; cmd_stride = 13'd1; wvalid = 1'b1; wdata = dpat(20);
        @(negedge clk); cmd_valid = 1'b0; #1;
        check("f_we0",   128'(mem_we),         128'(3'b001));
        check("f_addr0", 128'(mem_addr[12:0]), 128'(13'h200));
        @(negedge clk); wdata = dpat(21); #1;
        check("f_we1",   128'(mem_we),         128'(3'b001));
        check("f_addr1", 128'(mem_addr[12:0]), 128'(13'h201));
        check("f_wrdy1", 128'(wready),         128'(1'b1));
        reset = 1'b1;
        #1;
        check("f_rst_busy", 128'(busy),   128'(1'b0));
        check("f_rst_wrdy", 128'(wready), 128'(1'b0));
        check("f_rst_rv",   128'(rvalid), 128'(1'b0));
        check("f_rst_we",   128'(mem_we), 128'(3'b000));
        @(negedge clk); reset = 1'b0; wvalid = 1'b0; cmd_write = 1'b0; #1;
        check("f_rel_rdy",  128'(cmd_ready), 128'(1'b1));
        check("f_rel_busy", 128'(busy),      128'(1'b0));

        // New command after reset: read back first word of the ch1 write
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_write = 1'b0; cmd_addr = 13'h010;
        cmd_len = 8'd0; cmd_stride = 13'd0;
        #1 check("g_rdy0", 128'(cmd_ready), 128'(1'b1));
        @(negedge clk); cmd_valid = 1'b0; #1;
        check("g_busy1", 128'(busy),             128'(1'b1));
        check("g_addr1", 128'(mem_addr[25:13]), 128'(13'h010));
        @(negedge clk); #1;
        check("g_rv2",   128'(rvalid), 128'(1'b0));
        check("g_busy2", 128'(busy),   128'(1'b1));
        @(negedge clk); #1;
        check("g_rv3",   128'(rvalid), 128'(1'b1));
        check("g_rd3",   rdata,        dpat(0));
        @(negedge clk); #1;
        check("g_rv4",   128'(rvalid), 128'(1'b0));
        check("g_busy4", 128'(busy),   128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
